// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg
//    Constants and names shared by the writeback arbiter, its requester
//    interface, the round-robin grant sub-module and the testbench.
//    No ports.
package regfile_wb_arbiter_pkg;

   localparam int REG_IDX_W    = 5;
   localparam int XLEN         = 32;
   localparam int NREQ_DEFAULT = 3;
   localparam int NUM_REGS     = 1 << REG_IDX_W;

   // Requester positions on the writeback bus
   typedef enum int unsigned {
      REQ_ALU  = 0,
      REQ_LOAD = 1,
      REQ_CSR  = 2
   } req_idx_e;

   // Width of an index into n requesters (at least one bit)
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
//    Writeback request bus between the execution units and the arbiter.
//    Signals:
//       req_valid [NREQ]         per-requester writeback request
//       req_ready [NREQ]         per-requester grant (one-hot or zero)
//       req_rd    [NREQ*5]       destination register per requester
//       req_data  [NREQ*32]      writeback data per requester
//    Modports: master (requesters), slave (arbiter).
interface regfile_wb_arbiter_if
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NREQ = NREQ_DEFAULT
);

   logic [NREQ-1:0]           req_valid;
   logic [NREQ-1:0]           req_ready;
   logic [NREQ*REG_IDX_W-1:0] req_rd;
   logic [NREQ*XLEN-1:0]      req_data;

   modport master (
      output req_valid,
      output req_rd,
      output req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_rd,
      input  req_data,
      output req_ready
   );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter
//    Round-robin grant among N requesters. The grant goes to the first
//    valid requester at or after rr_ptr (wrapping); every grant is a
//    handshake, after which rr_ptr moves just past the winner.
//    Ports:
//       clock      rising-edge clock
//       RESET      synchronous active-high reset (forces grant to 0)
//       req   [N]  request vector
//       grant [N]  one-hot grant or zero, combinational
module rr_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int N = NREQ_DEFAULT
) (
   input  logic         clock,
   input  logic         RESET,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant
);

   localparam int PW = ptr_width(N);

   logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [2*N-1:0] req_rot;
   logic [PW:0]    off_sum;
   logic [PW-1:0]  gnt_idx;
   logic           gnt_any;

   // Rotating the doubled vector puts requester rr_ptr at bit 0, so the
   // lowest set bit is the winner's distance from rr_ptr.
   assign req_rot = {req, req} >> rr_ptr_q;

   always_comb begin
      off_sum = '0;
      gnt_any = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            off_sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
            gnt_any = !RESET;
         end
      end
      if (off_sum >= (PW+1)'(N)) begin
         off_sum = off_sum - (PW+1)'(N);
      end
      gnt_idx = off_sum[PW-1:0];
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_grant
      assign grant[gi] = gnt_any && (gnt_idx == PW'(gi));
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (gnt_any) begin
         rr_ptr_d = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (RESET) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//    Arbitrates writeback requesters onto the single register-file write
//    port and keeps a 2-bit pending-write scoreboard for x1..x31.
//    Optional feature macro: WB_FORWARD_EN (adds rs1_fwd/rs2_fwd/fwd_data).
//    Ports:
//       clock, RESET            clock; synchronous active-high reset
//       wb (slave)              requester bus (req_valid/ready/rd/data)
//       wr_en, write_select,    registered register-file write port
//       data_in
//       issue_valid, issue_rd,  decode claims a pending write
//       issue_ready
//       chk_rs1/2, rs1/2_busy   source-register busy lookup
//       rs1/2_fwd, fwd_data     (WB_FORWARD_EN only) bypass of this
//                               cycle's writeback to a waiting source
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NREQ = NREQ_DEFAULT
) (
   input  logic                 clock,
   input  logic                 RESET,
   regfile_wb_arbiter_if.slave  wb,
   output logic                 wr_en,
   output logic [REG_IDX_W-1:0] write_select,
   output logic [XLEN-1:0]      data_in,
   input  logic                 issue_valid,
   input  logic [REG_IDX_W-1:0] issue_rd,
   output logic                 issue_ready,
   input  logic [REG_IDX_W-1:0] chk_rs1,
   input  logic [REG_IDX_W-1:0] chk_rs2,
   output logic                 rs1_busy,
   output logic                 rs2_busy
`ifdef WB_FORWARD_EN
   ,
   output logic                 rs1_fwd,
   output logic                 rs2_fwd,
   output logic [XLEN-1:0]      fwd_data
`endif
);

   logic [NREQ-1:0]      grant;
   logic                 hs;
   logic [REG_IDX_W-1:0] gnt_rd;
   logic [XLEN-1:0]      gnt_data;

   logic                 wr_en_q, wr_en_d;
   logic [REG_IDX_W-1:0] write_select_q, write_select_d;
   logic [XLEN-1:0]      data_in_q, data_in_d;

   // Two bits per register; x0 slot is tied to zero
   logic [2*NUM_REGS-1:0] cnt_flat;
   logic [1:0]            cnt_issue, cnt_rs1, cnt_rs2;
   logic                  issue_fire;

   rr_arbiter #(.N(NREQ)) u_rr_arbiter (
      .clock (clock),
      .RESET (RESET),
      .req   (wb.req_valid),
      .grant (grant)
   );

   assign wb.req_ready = grant;
   assign hs           = |grant;

   // Grant is one-hot, so an OR-mux selects the winner's payload
   always_comb begin
      gnt_rd   = '0;
      gnt_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            gnt_rd   = gnt_rd   | wb.req_rd[i*REG_IDX_W +: REG_IDX_W];
            gnt_data = gnt_data | wb.req_data[i*XLEN +: XLEN];
         end
      end
   end

   // Writes to x0 still complete the handshake but never reach the file
   always_comb begin
      wr_en_d        = hs && (gnt_rd != '0);
      write_select_d = hs ? gnt_rd   : write_select_q;
      data_in_d      = hs ? gnt_data : data_in_q;
   end

   always_ff @(posedge clock) begin
      if (RESET) begin
         wr_en_q        <= 1'b0;
         write_select_q <= '0;
         data_in_q      <= '0;
      end else begin
         wr_en_q        <= wr_en_d;
         write_select_q <= write_select_d;
         data_in_q      <= data_in_d;
      end
   end

   assign wr_en        = wr_en_q;
   assign write_select = write_select_q;
   assign data_in      = data_in_q;

   assign cnt_issue   = cnt_flat[{issue_rd, 1'b0} +: 2];
   assign cnt_rs1     = cnt_flat[{chk_rs1, 1'b0} +: 2];
   assign cnt_rs2     = cnt_flat[{chk_rs2, 1'b0} +: 2];
   assign issue_ready = (issue_rd == '0) || (cnt_issue != 2'd3);
   assign issue_fire  = issue_valid && issue_ready;

   assign cnt_flat[1:0] = 2'd0;

   for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_sb
      logic [1:0] cnt_q, cnt_d;
      logic       inc, dec;

      assign inc = issue_fire && (issue_rd == REG_IDX_W'(gi));
      assign dec = hs && (gnt_rd == REG_IDX_W'(gi));

      // A claim and a writeback on the same register cancel out
      always_comb begin
         cnt_d = cnt_q;
         if (inc && !dec) begin
            cnt_d = cnt_q + 2'd1;
         end else if (dec && !inc && (cnt_q != 2'd0)) begin
            cnt_d = cnt_q - 2'd1;
         end
      end

      always_ff @(posedge clock) begin
         if (RESET) begin
            cnt_q <= 2'd0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign cnt_flat[2*gi +: 2] = cnt_q;
   end

`ifdef WB_FORWARD_EN
   // Forward only when this writeback is the last one outstanding, so the
   // bypassed value is final for the waiting source.
   assign rs1_fwd  = hs && (chk_rs1 != '0) && (gnt_rd == chk_rs1) && (cnt_rs1 == 2'd1);
   assign rs2_fwd  = hs && (chk_rs2 != '0) && (gnt_rd == chk_rs2) && (cnt_rs2 == 2'd1);
   assign fwd_data = gnt_data;
   assign rs1_busy = (cnt_rs1 != 2'd0) && !rs1_fwd;
   assign rs2_busy = (cnt_rs2 != 2'd0) && !rs2_fwd;
`else
   assign rs1_busy = (cnt_rs1 != 2'd0);
   assign rs2_busy = (cnt_rs2 != 2'd0);
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//    Directed-vector bench for regfile_wb_arbiter. Covers reset, round-robin
//    contention, x0 writes, scoreboard saturation, simultaneous claim and
//    writeback, forwarding (WB_FORWARD_EN) and reset during a write.
module tb_regfile_wb_arbiter;
   import regfile_wb_arbiter_pkg::*;

   logic        clock = 1'b0;
   logic        RESET;
   logic        wr_en;
   logic [4:0]  write_select;
   logic [31:0] data_in;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        issue_ready;
   logic [4:0]  chk_rs1, chk_rs2;
   logic        rs1_busy, rs2_busy;
`ifdef WB_FORWARD_EN
   logic        rs1_fwd, rs2_fwd;
   logic [31:0] fwd_data;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clock = ~clock;

   regfile_wb_arbiter_if #(.NREQ(3)) wb_if ();

   regfile_wb_arbiter #(.NREQ(3)) dut (
      .clock        (clock),
      .RESET        (RESET),
      .wb           (wb_if.slave),
      .wr_en        (wr_en),
      .write_select (write_select),
      .data_in      (data_in),
      .issue_valid  (issue_valid),
      .issue_rd     (issue_rd),
      .issue_ready  (issue_ready),
      .chk_rs1      (chk_rs1),
      .chk_rs2      (chk_rs2),
      .rs1_busy     (rs1_busy),
      .rs2_busy     (rs2_busy)
`ifdef WB_FORWARD_EN
      ,
      .rs1_fwd      (rs1_fwd),
      .rs2_fwd      (rs2_fwd),
      .fwd_data     (fwd_data)
`endif
   );

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Drive a single requester's payload, leaving the others untouched
   task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] d);
      wb_if.req_rd[i*5 +: 5]    = rd;
      wb_if.req_data[i*32 +: 32] = d;
   endtask

   logic [2:0] exp_gnt [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
   logic [4:0] exp_ws  [4] = '{5'd1, 5'd2, 5'd3, 5'd1};
   logic [31:0] exp_dat[4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA0};

   initial begin
      // Reset for two cycles with every input high
      RESET           = 1'b1;
      wb_if.req_valid = '1;
      wb_if.req_rd    = '1;
      wb_if.req_data  = '1;
      issue_valid     = 1'b1;
      issue_rd        = 5'h1f;
      chk_rs1         = 5'h1f;
      chk_rs2         = 5'h1f;
      #1;
      check_vec("rst_ready_c0", 32'(wb_if.req_ready), 32'd0);
      @(negedge clock);
      @(negedge clock);
      #1;
      check_vec("rst_ready", 32'(wb_if.req_ready), 32'd0);
      check_vec("rst_wr_en", 32'(wr_en), 32'd0);
      check_vec("rst_wsel", 32'(write_select), 32'd0);
      check_vec("rst_data", data_in, 32'd0);
      check_vec("rst_rs1_busy", 32'(rs1_busy), 32'd0);

      RESET           = 1'b0;
      wb_if.req_valid = '0;
      issue_valid     = 1'b0;
      chk_rs1         = 5'd0;
      chk_rs2         = 5'd0;
      @(negedge clock);
      check_vec("post_rst_wr_en", 32'(wr_en), 32'd0);

      // Contention: all three valid, rd 1/2/3
      set_req(0, 5'd1, 32'hA0);
      set_req(1, 5'd2, 32'hA1);
      set_req(2, 5'd3, 32'hA2);
      wb_if.req_valid = 3'b111;
      for (int k = 0; k < 4; k++) begin
         #1;
         check_vec($sformatf("cont_grant%0d", k), 32'(wb_if.req_ready), 32'(exp_gnt[k]));
         @(negedge clock);
         check_vec($sformatf("cont_wsel%0d", k), 32'(write_select), 32'(exp_ws[k]));
         check_vec($sformatf("cont_wr_en%0d", k), 32'(wr_en), 32'd1);
         check_vec($sformatf("cont_data%0d", k), data_in, exp_dat[k]);
      end
      wb_if.req_valid = '0;
      @(negedge clock);
      check_vec("idle_wr_en", 32'(wr_en), 32'd0);
      check_vec("idle_wsel_hold", 32'(write_select), 32'd1);
      check_vec("idle_data_hold", data_in, 32'hA0);

      // ALU writes x0: handshake happens, no write
      set_req(0, 5'd0, 32'hDEADBEEF);
      wb_if.req_valid = 3'b001;
      #1;
      check_vec("x0_grant", 32'(wb_if.req_ready), 32'd1);
      @(negedge clock);
      wb_if.req_valid = '0;
      check_vec("x0_wr_en", 32'(wr_en), 32'd0);

      // Scoreboard: three claims of x5, fourth refused
      issue_valid = 1'b1;
      issue_rd    = 5'd5;
      chk_rs1     = 5'd5;
      for (int k = 0; k < 4; k++) begin
         #1;
         check_vec($sformatf("sb_issue_ready%0d", k), 32'(issue_ready), (k < 3) ? 32'd1 : 32'd0);
         @(negedge clock);
      end
      issue_valid = 1'b0;
      #1;
      check_vec("sb_busy_full", 32'(rs1_busy), 32'd1);
      set_req(1, 5'd5, 32'h55);
      for (int k = 0; k < 3; k++) begin
         wb_if.req_valid = 3'b010;
         @(negedge clock);
         wb_if.req_valid = '0;
         #1;
         check_vec($sformatf("sb_busy_after_wb%0d", k), 32'(rs1_busy), (k < 2) ? 32'd1 : 32'd0);
      end

      // Simultaneous claim and writeback of x7 with count 1
      @(negedge clock);
      issue_valid = 1'b1;
      issue_rd    = 5'd7;
      chk_rs1     = 5'd7;
      @(negedge clock);
      set_req(1, 5'd7, 32'h77);
      wb_if.req_valid = 3'b010;
      #1;
      check_vec("sim_issue_ready", 32'(issue_ready), 32'd1);
      @(negedge clock);
      issue_valid     = 1'b0;
      wb_if.req_valid = '0;
      #1;
      check_vec("sim_busy_kept", 32'(rs1_busy), 32'd1);
      @(negedge clock);
      wb_if.req_valid = 3'b010;
      @(negedge clock);
      wb_if.req_valid = '0;
      #1;
      check_vec("sim_busy_cleared", 32'(rs1_busy), 32'd0);

      // Writeback of x9 (count 1) while rs2 waits on it
      @(negedge clock);
      issue_valid = 1'b1;
      issue_rd    = 5'd9;
      chk_rs2     = 5'd9;
      @(negedge clock);
      issue_valid = 1'b0;
      set_req(1, 5'd9, 32'h1234);
      wb_if.req_valid = 3'b010;
      #1;
`ifdef WB_FORWARD_EN
      check_vec("fwd_rs2_fwd", 32'(rs2_fwd), 32'd1);
      check_vec("fwd_data", fwd_data, 32'h1234);
      check_vec("fwd_rs2_busy", 32'(rs2_busy), 32'd0);
`else
      check_vec("nofwd_rs2_busy", 32'(rs2_busy), 32'd1);
`endif
      @(negedge clock);
      wb_if.req_valid = '0;
      #1;
      check_vec("x9_busy_after", 32'(rs2_busy), 32'd0);
      check_vec("x9_wsel", 32'(write_select), 32'd9);
      check_vec("x9_data", data_in, 32'h1234);

      // Reset arrives while a write is being offered
      set_req(0, 5'd4, 32'h4444);
      wb_if.req_valid = 3'b001;
      RESET           = 1'b1;
      #1;
      check_vec("inflight_ready", 32'(wb_if.req_ready), 32'd0);
      @(negedge clock);
      check_vec("inflight_wr_en", 32'(wr_en), 32'd0);
      check_vec("inflight_data", data_in, 32'd0);
      RESET           = 1'b0;
      wb_if.req_valid = '0;
      @(negedge clock);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, number of writeback requesters (index 0 ALU, 1 load unit, 2 CSR).
REQ-002 The block SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port req_valid  input  NREQ  per-requester writeback request.
REQ-005 The block SHALL have port req_ready  output  NREQ  per-requester grant, one-hot or zero.
REQ-006 The block SHALL have port req_rd  input  NREQ*5  destination register per requester.
REQ-007 The block SHALL have port req_data  input  NREQ*32  writeback data per requester.
REQ-008 The block SHALL have port wr_en  output  1  register-file write enable, registered.
REQ-009 The block SHALL have port write_select  output  5  register-file write index, registered.
REQ-010 The block SHALL have port data_in  output  32  register-file write data, registered.
REQ-011 The block SHALL have port issue_valid  input  1  decode announces a pending write to issue_rd.
REQ-012 The block SHALL have port issue_rd  input  5  register being claimed.
REQ-013 The block SHALL have port issue_ready  output  1  claim accepted this cycle.
REQ-014 The block SHALL have ports chk_rs1 and chk_rs2  input  5 each  source registers to check.
REQ-015 The block SHALL have ports rs1_busy and rs2_busy  output  1 each  source has pending writes.

Function
REQ-016 req_ready SHALL be combinational: at most one bit set, granted to the lowest-index valid requester at or after rr_ptr, wrapping modulo NREQ.
REQ-017 A handshake SHALL occur on the rising edge where req_valid[i] and req_ready[i] are both 1; rr_ptr SHALL then become (i+1) mod NREQ, else hold.
REQ-018 On a handshake, wr_en, write_select and data_in SHALL be updated on the same edge, giving 1-cycle latency, and SHALL be stable through the following falling edge.
REQ-019 A handshake with req_rd==0 SHALL be accepted but SHALL drive wr_en=0.
REQ-020 With no handshake, wr_en SHALL be 0 on the next cycle; write_select and data_in SHALL hold.
REQ-021 The scoreboard SHALL keep a 2-bit pending count per register x1..x31; x0 SHALL always read count 0.
REQ-022 issue_ready SHALL be 0 when count[issue_rd]==3, else 1; issue_rd==0 SHALL always be ready and change nothing.
REQ-023 An accepted issue SHALL increment count[issue_rd]; a handshake SHALL decrement count[req_rd], saturating at 0.
REQ-024 An accepted issue and a handshake to the same register in one cycle SHALL leave the count unchanged.
REQ-025 rsN_busy SHALL be (count[chk_rsN]!=0), combinational from current state.

Reset
REQ-026 While RESET is sampled high on a rising edge, wr_en SHALL go to 0, write_select to 0, data_in to 0, rr_ptr to 0 and all counts to 0.
REQ-027 Handshakes and issues in a reset cycle SHALL be discarded, and req_ready SHALL be 0 during RESET.
REQ-028 An in-flight write SHALL be dropped when RESET arrives.

Configuration
REQ-029 With WB_FORWARD_EN defined, the block SHALL add rs1_fwd and rs2_fwd outputs (1 bit each) and fwd_data (32 bits), asserted when the granted request this cycle targets chk_rsN (nonzero) with count==1, and rsN_busy SHALL then be masked to 0.
REQ-030 Without WB_FORWARD_EN, these ports SHALL be absent and busy SHALL follow REQ-025.

Structure
REQ-031 A shared package SHALL hold the REG_IDX_W=5 and XLEN=32 constants, the NREQ default, and the requester index names.
REQ-032 The round-robin grant logic SHALL be one sub-module, rr_arbiter.

Verification
REQ-033 A reset test SHALL apply RESET for 2 cycles with all inputs high and SHALL see wr_en=0, req_ready=0 and rs1_busy=0.
REQ-034 A contention test SHALL hold all three valid with rd 1/2/3; grants SHALL go 0,1,2,0 and write_select SHALL be 1,2,3,1, each one cycle after its grant.
REQ-035 An x0 test SHALL have ALU write rd=0, data 0xDEADBEEF; the handshake SHALL occur with wr_en=0.
REQ-036 A scoreboard test SHALL issue rd=5 three times; issue_ready SHALL be 0 on the fourth issue, and rs1_busy (chk_rs1=5) SHALL clear only after three writebacks.
REQ-037 A simultaneous test SHALL issue rd=7 while the load unit writes rd=7 with count 1; count SHALL stay 1 and rs1_busy SHALL stay 1.
REQ-038 A forwarding test (WB_FORWARD_EN) SHALL write rd=9, data 0x1234, with count 1 and chk_rs2=9; rs2_fwd SHALL be 1, fwd_data SHALL be 0x1234 and rs2_busy SHALL be 0.
